// File: rtl/pool_window_buffer_if.sv
// pool_window_buffer_if: pixel stream in, packed NxN window stream out
interface pool_window_buffer_if #(
  parameter int N       = 3,
  parameter int BitSize = 8
);
  logic                    in_valid;
  logic [BitSize-1:0]      in_data;
  logic                    out_valid;
  logic [BitSize*N*N-1:0]  out_data;
  logic                    out_last;
  modport master (output in_valid, in_data, input out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_last);
endinterface

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: raster pixel stream to non-overlapping NxN windows (stride N)
module pool_window_buffer #(
  parameter int N           = 3,
  parameter int BitSize     = 8,
  parameter int ImageWidth  = 24,
  parameter int ImageHeight = 24
) (
  input  logic                      clk,
  input  logic                      res_n,
  pool_window_buffer_if.slave       bus
);
  localparam int CW  = $clog2(ImageWidth);
  localparam int RW  = $clog2(ImageHeight);
  localparam int SW  = $clog2(N);
  localparam int RBW = N > 2 ? $clog2(N - 1) : 1;
  localparam int SRW = (N - 1) * BitSize;
  localparam int WW  = (ImageWidth / N) * N;
  localparam int HH  = (ImageHeight / N) * N;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [SW-1:0]          csub;
  logic [SW-1:0]          rsub;
  logic [BitSize-1:0]     rbuf [N-1][ImageWidth];
  logic [SRW-1:0]         sreg;
  logic [BitSize*N*N-1:0] win;
  logic [CW-1:0]          base;
  logic                   last_col;
  logic                   last_row;
  logic                   done;
  logic                   frame_end;
  always_comb begin
    last_col  = col == CW'(ImageWidth - 1);
    last_row  = row == RW'(ImageHeight - 1);
    base      = col - CW'(N - 1);
    done      = bus.in_valid && rsub == SW'(N - 1) && csub == SW'(N - 1)
                && int'(col) < WW && int'(row) < HH;
    frame_end = done && row == RW'(HH - 1) && col == CW'(WW - 1);
  end
  // Top N-1 rows come from the row buffers, the bottom row from the shift register plus the live pixel
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (r < N - 1) begin : g_buf
        assign win[(r*N+c)*BitSize +: BitSize] = rbuf[r][base + CW'(c)];
      end else if (c < N - 1) begin : g_sreg
        assign win[(r*N+c)*BitSize +: BitSize] = sreg[c*BitSize +: BitSize];
      end else begin : g_live
        assign win[(r*N+c)*BitSize +: BitSize] = bus.in_data;
      end
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      col           <= '0;
      row           <= '0;
      csub          <= '0;
      rsub          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= done;
      bus.out_last  <= frame_end;
      if (done) bus.out_data <= win;
      if (bus.in_valid) begin
        col  <= last_col ? '0 : col + 1'b1;
        csub <= (last_col || csub == SW'(N - 1)) ? '0 : csub + 1'b1;
        if (last_col) begin
          row  <= last_row ? '0 : row + 1'b1;
          rsub <= (last_row || rsub == SW'(N - 1)) ? '0 : rsub + 1'b1;
        end
      end
    end
  end
  // Storage needs no reset: every window reads only locations written earlier in its own row group
  always_ff @(posedge clk) begin
    if (bus.in_valid && rsub != SW'(N - 1)) rbuf[RBW'(rsub)][col] <= bus.in_data;
    if (bus.in_valid && rsub == SW'(N - 1)) sreg <= SRW'({bus.in_data, sreg} >> BitSize);
  end
endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: three configurations driven against an image-array reference model
module tb_pool_window_buffer;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;
  pool_window_buffer_if #(.N(2), .BitSize(8)) if_a ();
  pool_window_buffer_if #(.N(3), .BitSize(8)) if_b ();
  pool_window_buffer_if #(.N(2), .BitSize(8)) if_c ();
  pool_window_buffer #(.N(2), .BitSize(8), .ImageWidth(4), .ImageHeight(4)) dut_a (.clk(clk), .res_n(res_n), .bus(if_a.slave));
  pool_window_buffer #(.N(3), .BitSize(8), .ImageWidth(7), .ImageHeight(7)) dut_b (.clk(clk), .res_n(res_n), .bus(if_b.slave));
  pool_window_buffer #(.N(2), .BitSize(8), .ImageWidth(2), .ImageHeight(2)) dut_c (.clk(clk), .res_n(res_n), .bus(if_c.slave));
  int total = 0;
  int passed = 0;
  int cfg_n [3] = '{2, 3, 2};
  int cfg_w [3] = '{4, 7, 2};
  int cfg_h [3] = '{4, 7, 2};
  int pix_idx [3] = '{0, 0, 0};
  int win_cnt [3];
  int last_cnt [3];
  logic [71:0] first_win [3];
  logic [71:0] last_win [3];
  logic [7:0] img [3][64];
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic drive(input int k, input bit v, input logic [7:0] d);
    if_a.in_valid = k == 0 && v;
    if_b.in_valid = k == 1 && v;
    if_c.in_valid = k == 2 && v;
    if_a.in_data = d;
    if_b.in_data = d;
    if_c.in_data = d;
  endtask
  task automatic clear_counts();
    for (int k = 0; k < 3; k++) begin
      win_cnt[k] = 0;
      last_cnt[k] = 0;
      first_win[k] = '0;
      last_win[k] = '0;
    end
  endtask
  task automatic step(input int k, input bit v, input logic [7:0] d);
    int n, w, h, p, pr, pc;
    bit done, lst;
    logic [71:0] exp, od;
    logic ov, ol;
    n = cfg_n[k];
    w = cfg_w[k];
    h = cfg_h[k];
    exp = '0;
    done = 1'b0;
    lst = 1'b0;
    if (v) begin
      p = pix_idx[k];
      pr = p / w;
      pc = p % w;
      img[k][p] = d;
      done = pr % n == n - 1 && pc % n == n - 1 && pc < (w / n) * n && pr < (h / n) * n;
      lst = done && pr == (h / n) * n - 1 && pc == (w / n) * n - 1;
      if (done)
        for (int r = 0; r < n; r++)
          for (int c = 0; c < n; c++)
            exp[(r*n+c)*8 +: 8] = img[k][(pr - n + 1 + r) * w + pc - n + 1 + c];
      pix_idx[k] = (p + 1) % (w * h);
    end
    drive(k, v, d);
    @(posedge clk);
    #1;
    case (k)
      0: begin ov = if_a.out_valid; od = 72'(if_a.out_data); ol = if_a.out_last; end
      1: begin ov = if_b.out_valid; od = 72'(if_b.out_data); ol = if_b.out_last; end
      default: begin ov = if_c.out_valid; od = 72'(if_c.out_data); ol = if_c.out_last; end
    endcase
    chk($sformatf("valid%0d", k), 72'(ov), 72'(done));
    chk($sformatf("last%0d", k), 72'(ol), 72'(lst));
    if (done) chk($sformatf("data%0d", k), od, exp);
    if (ov) begin
      if (win_cnt[k] == 0) first_win[k] = od;
      win_cnt[k]++;
      last_win[k] = od;
    end
    if (ol) last_cnt[k]++;
  endtask
  task automatic frame(input int k, input int mode);
    for (int i = 0; i < cfg_w[k] * cfg_h[k]; i++) begin
      if (mode == 1 && i > 0) step(k, 1'b0, 8'($urandom));
      if (mode == 2) while ($urandom_range(3) == 0) step(k, 1'b0, 8'($urandom));
      step(k, 1'b1, mode == 2 ? 8'($urandom) : 8'(i));
    end
  endtask
  task automatic check_a_zero(input string tag);
    chk({tag, "_valid"}, 72'(if_a.out_valid), 72'(0));
    chk({tag, "_data"}, 72'(if_a.out_data), 72'(0));
    chk({tag, "_last"}, 72'(if_a.out_last), 72'(0));
  endtask
  initial begin
    drive(0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_a_zero("rst");
    chk("rst_b_valid", 72'(if_b.out_valid), 72'(0));
    res_n = 1'b1;
    clear_counts();
    frame(0, 0);
    chk("a_wins", 72'(win_cnt[0]), 72'(4));
    chk("a_lasts", 72'(last_cnt[0]), 72'(1));
    chk("a_first", first_win[0], 72'h05040100);
    chk("a_final", last_win[0], 72'h0f0e0b0a);
    clear_counts();
    frame(0, 1);
    chk("a_toggle_wins", 72'(win_cnt[0]), 72'(4));
    chk("a_toggle_first", first_win[0], 72'h05040100);
    clear_counts();
    frame(1, 0);
    chk("b_wins", 72'(win_cnt[1]), 72'(4));
    chk("b_lasts", 72'(last_cnt[1]), 72'(1));
    chk("b_first", first_win[1], 72'h100f0e090807020100);
    clear_counts();
    step(2, 1'b1, 8'h80);
    step(2, 1'b1, 8'h7f);
    step(2, 1'b1, 8'hff);
    step(2, 1'b1, 8'h00);
    chk("c_signed", last_win[2], 72'h00ff7f80);
    chk("c_wins", 72'(win_cnt[2]), 72'(1));
    for (int i = 0; i < 7; i++) step(0, 1'b1, 8'(i));
    res_n = 1'b0;
    #1;
    check_a_zero("midrst");
    drive(0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check_a_zero("midrst_hold");
    res_n = 1'b1;
    for (int k = 0; k < 3; k++) pix_idx[k] = 0;
    clear_counts();
    frame(0, 0);
    chk("restart_wins", 72'(win_cnt[0]), 72'(4));
    chk("restart_first", first_win[0], 72'h05040100);
    clear_counts();
    frame(0, 0);
    frame(0, 0);
    chk("b2b_wins", 72'(win_cnt[0]), 72'(8));
    chk("b2b_lasts", 72'(last_cnt[0]), 72'(2));
    clear_counts();
    repeat (3) frame(0, 2);
    repeat (2) frame(1, 2);
    chk("rand_a_wins", 72'(win_cnt[0]), 72'(12));
    chk("rand_b_wins", 72'(win_cnt[1]), 72'(8));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
